// File: rtl/ram_frame_reader.sv
// ram_frame_reader: fetches a LEN-byte frame from the frame RAM read port and streams it out on a byte valid/ready interface.
// Ports: clk, reset_n (async active-low); start/base_addr/len frame request, sampled in IDLE;
//        ram_rd/ram_rd_addr/ram_dout RAM read port (combinational data);
//        o_valid/o_data/o_ready byte stream; busy/done status.
// Optional: RAM_FRAME_READER_CHECKSUM_EN appends an XOR checksum byte after each non-empty frame.
module ram_frame_reader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] IDLE_BYTE = 8'hE1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              o_ready,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
`ifdef RAM_FRAME_READER_CHECKSUM_EN
    CSUM,
`endif
    DONE
  } state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, ram_rd_addr_q, ram_rd_addr_d;
  logic [ADDR_W:0] rem_q, rem_d;
  logic [DATA_W-1:0] o_data_q, o_data_d;
  logic ram_rd_q, ram_rd_d, o_valid_q, o_valid_d, busy_q, busy_d, done_q, done_d;
`ifdef RAM_FRAME_READER_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q, acc_d;
`endif
  assign ram_rd = ram_rd_q;
  assign ram_rd_addr = ram_rd_addr_q;
  assign o_valid = o_valid_q;
  assign o_data = o_data_q;
  assign busy = busy_q;
  assign done = done_q;
  // Outputs are registered, so each one is set on the transition into the state that presents it.
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    ram_rd_d = 1'b0;
    ram_rd_addr_d = ram_rd_addr_q;
    o_valid_d = o_valid_q;
    o_data_d = o_data_q;
    busy_d = busy_q;
    done_d = 1'b0;
`ifdef RAM_FRAME_READER_CHECKSUM_EN
    acc_d = acc_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        busy_d = 1'b1;
`ifdef RAM_FRAME_READER_CHECKSUM_EN
        acc_d = '0;
`endif
        if (len != '0) begin
          state_d = FETCH;
          addr_d = base_addr;
          rem_d = len;
          ram_rd_d = 1'b1;
          ram_rd_addr_d = base_addr;
        end else begin
          state_d = DONE;
          done_d = 1'b1;
        end
      end
      FETCH: begin
        o_data_d = ram_dout;
        o_valid_d = 1'b1;
        addr_d = addr_q + ADDR_W'(1);
        rem_d = rem_q - (ADDR_W+1)'(1);
        state_d = SEND;
      end
      SEND: if (o_ready) begin
        o_valid_d = 1'b0;
        o_data_d = IDLE_BYTE;
`ifdef RAM_FRAME_READER_CHECKSUM_EN
        acc_d = acc_q ^ o_data_q;
`endif
        if (rem_q != '0) begin
          state_d = FETCH;
          ram_rd_d = 1'b1;
          ram_rd_addr_d = addr_q;
        end else begin
`ifdef RAM_FRAME_READER_CHECKSUM_EN
          state_d = CSUM;
          o_valid_d = 1'b1;
          o_data_d = acc_q ^ o_data_q;
`else
          state_d = DONE;
          done_d = 1'b1;
`endif
        end
      end
`ifdef RAM_FRAME_READER_CHECKSUM_EN
      CSUM: if (o_ready) begin
        o_valid_d = 1'b0;
        o_data_d = IDLE_BYTE;
        state_d = DONE;
        done_d = 1'b1;
      end
`endif
      DONE: begin
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      ram_rd_q <= 1'b0;
      ram_rd_addr_q <= '0;
      o_valid_q <= 1'b0;
      o_data_q <= IDLE_BYTE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef RAM_FRAME_READER_CHECKSUM_EN
      acc_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      ram_rd_q <= ram_rd_d;
      ram_rd_addr_q <= ram_rd_addr_d;
      o_valid_q <= o_valid_d;
      o_data_q <= o_data_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef RAM_FRAME_READER_CHECKSUM_EN
      acc_q <= acc_d;
`endif
    end
  end
endmodule

// File: tb/tb_ram_frame_reader.sv
// tb_ram_frame_reader: directed self-checking bench for ram_frame_reader with a behavioural frame RAM.
module tb_ram_frame_reader;
  localparam int AW = 12;
  localparam int DW = 8;
`ifdef RAM_FRAME_READER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic o_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] len = '0;
  logic ram_rd, o_valid, busy, done;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_dout, o_data;
  logic [DW-1:0] mem [0:4095];
  int tests = 0;
  int fails = 0;
  logic [DW-1:0] got_b[$];
  logic [AW-1:0] got_a[$];
  int busy_cyc;
  always #5 clk = ~clk;
  assign ram_dout = ram_rd ? mem[ram_rd_addr] : 8'hE1;
  ram_frame_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .len(len),
    .ram_rd(ram_rd), .ram_rd_addr(ram_rd_addr), .ram_dout(ram_dout),
    .o_valid(o_valid), .o_data(o_data), .o_ready(o_ready), .busy(busy), .done(done)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_ram_rd"}, 32'(ram_rd), 32'h0);
    check({tag, "_o_valid"}, 32'(o_valid), 32'h0);
    check({tag, "_o_data"}, 32'(o_data), 32'hE1);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
  endtask
  task automatic start_frame(input logic [AW-1:0] b, input logic [AW:0] n);
    got_b.delete();
    got_a.delete();
    busy_cyc = 0;
    base_addr = b;
    len = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  // Samples one cycle at a time until done; optionally pulses start at a given cycle or in the done cycle.
  task automatic collect(input int poke_cyc, input bit poke_done);
    bit seen = 1'b0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      if (busy) busy_cyc++;
      if (ram_rd) got_a.push_back(ram_rd_addr);
      if (o_valid && o_ready) got_b.push_back(o_data);
      seen = done;
      start = (c == poke_cyc) || (done && poke_done);
      tick();
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'h1);
    check("done_one_cycle", 32'(done), 32'h0);
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h010] = 8'h11; mem[12'h011] = 8'h22; mem[12'h012] = 8'h33;
    mem[12'hFFE] = 8'hA1; mem[12'hFFF] = 8'hA2; mem[12'h000] = 8'hA3;
    mem[12'h100] = 8'h5A; mem[12'h101] = 8'hC3;
    mem[12'h300] = 8'h01; mem[12'h301] = 8'h02; mem[12'h302] = 8'h03; mem[12'h303] = 8'h04;
    mem[12'h400] = 8'h77;
    mem[12'h500] = 8'h61; mem[12'h501] = 8'h62; mem[12'h502] = 8'h63; mem[12'h503] = 8'h64;
    mem[12'h600] = 8'h0F; mem[12'h601] = 8'hF0; mem[12'h602] = 8'h55;
    tick();
    check_idle("reset");
    check("reset_addr", 32'(ram_rd_addr), 32'h0);
    reset_n = 1'b1;
    tick();
    o_ready = 1'b1;
    start_frame(12'h010, 13'd3);
    collect(-1, 1'b0);
    check("f1_count", 32'(got_b.size()), 32'(3 + CS));
    check("f1_b0", 32'(got_b[0]), 32'h11);
    check("f1_b1", 32'(got_b[1]), 32'h22);
    check("f1_b2", 32'(got_b[2]), 32'h33);
    check("f1_rd_count", 32'(got_a.size()), 32'h3);
    check("f1_a0", 32'(got_a[0]), 32'h010);
    check("f1_a1", 32'(got_a[1]), 32'h011);
    check("f1_a2", 32'(got_a[2]), 32'h012);
    check("f1_busy", 32'(busy_cyc), 32'(7 + CS));
    check_idle("f1_after");
    start_frame(12'hFFE, 13'd3);
    collect(-1, 1'b0);
    check("wrap_count", 32'(got_b.size()), 32'(3 + CS));
    check("wrap_b0", 32'(got_b[0]), 32'hA1);
    check("wrap_b1", 32'(got_b[1]), 32'hA2);
    check("wrap_b2", 32'(got_b[2]), 32'hA3);
    check("wrap_a1", 32'(got_a[1]), 32'hFFF);
    check("wrap_a2", 32'(got_a[2]), 32'h000);
    o_ready = 1'b0;
    start_frame(12'h100, 13'd2);
    check("stall_fetch_rd", 32'(ram_rd), 32'h1);
    check("stall_fetch_addr", 32'(ram_rd_addr), 32'h100);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(o_valid), 32'h1);
      check("stall_data", 32'(o_data), 32'h5A);
      check("stall_no_rd", 32'(ram_rd), 32'h0);
      tick();
    end
    o_ready = 1'b1;
    collect(-1, 1'b0);
    check("stall_count", 32'(got_b.size()), 32'(2 + CS));
    check("stall_b0", 32'(got_b[0]), 32'h5A);
    check("stall_b1", 32'(got_b[1]), 32'hC3);
    check("stall_rd_count", 32'(got_a.size()), 32'h1);
    check("stall_a", 32'(got_a[0]), 32'h101);
    start_frame(12'h200, 13'd0);
    collect(-1, 1'b0);
    check("len0_busy", 32'(busy_cyc), 32'h1);
    check("len0_bytes", 32'(got_b.size()), 32'h0);
    check("len0_rd", 32'(got_a.size()), 32'h0);
    start_frame(12'h300, 13'd4);
    base_addr = 12'h400;
    len = 13'd1;
    collect(1, 1'b1);
    check("ign_count", 32'(got_b.size()), 32'(4 + CS));
    check("ign_b0", 32'(got_b[0]), 32'h01);
    check("ign_b3", 32'(got_b[3]), 32'h04);
    check("ign_rd_count", 32'(got_a.size()), 32'h4);
    check("ign_a3", 32'(got_a[3]), 32'h303);
    check("ign_busy", 32'(busy_cyc), 32'(9 + CS));
    tick();
    check_idle("ign_done_start");
    start_frame(12'h500, 13'd4);
    tick();
    tick();
    tick();
    check("rst_pre_valid", 32'(o_valid), 32'h1);
    check("rst_pre_data", 32'(o_data), 32'h62);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle("rst_async");
    check("rst_async_addr", 32'(ram_rd_addr), 32'h0);
    tick();
    check_idle("rst_held");
    reset_n = 1'b1;
    tick();
    check_idle("rst_release");
    start_frame(12'h010, 13'd3);
    collect(-1, 1'b0);
    check("post_rst_count", 32'(got_b.size()), 32'(3 + CS));
    check("post_rst_b0", 32'(got_b[0]), 32'h11);
    check("post_rst_b2", 32'(got_b[2]), 32'h33);
`ifdef RAM_FRAME_READER_CHECKSUM_EN
    start_frame(12'h600, 13'd3);
    collect(-1, 1'b0);
    check("cs_count", 32'(got_b.size()), 32'h4);
    check("cs_b2", 32'(got_b[2]), 32'h55);
    check("cs_sum", 32'(got_b[3]), 32'hAA);
    check("cs_busy", 32'(busy_cyc), 32'h8);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
